// File: rtl/copy_sched_pkg.sv
// Shared definitions for the copy-array scheduler and its bench.
// Holds the default array size and element width, the one-hot state codes,
// the copy mode codes, and the element-qualification helper that decides
// whether an element is copied under a given mode and pass.
package copy_sched_pkg;

  localparam int N_ELEM_DEF = 10;
  localparam int DW_DEF     = 4;

  typedef enum logic [2:0] {
    ST_INI  = 3'b001,
    ST_COPY = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  localparam logic [1:0] MODE_ALL = 2'b00;  // copy every element
  localparam logic [1:0] MODE_NEG = 2'b01;  // negatives only
  localparam logic [1:0] MODE_POS = 2'b10;  // non-negatives only
  localparam logic [1:0] MODE_TWO = 2'b11;  // negatives, then non-negatives

  // True when an element with sign bit 'neg' is written under 'mode'.
  // In two-pass mode, pass 0 takes negatives and pass 1 non-negatives.
  function automatic logic qualifies(input logic [1:0] mode,
                                     input logic       pass,
                                     input logic       neg);
    logic q;
    case (mode)
      MODE_ALL: q = 1'b1;
      MODE_NEG: q = neg;
      MODE_POS: q = ~neg;
      default:  q = pass ? ~neg : neg;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/copy_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   Clk, Reset  clock and asynchronous active-low reset
//   req         request vector, bit k = requester k
//   advance     pulse when the current job is released
//   served      index of the requester whose job is being released
//   grant       combinational one-hot winner (00 when no request)
// The 1-bit pointer favours requester 0 after reset and, on every release,
// moves to favour the requester that was not just served.
module copy_rr_arb2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic [1:0] grant
);

  logic ptr_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= ~served;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/copy_array_scheduler.sv
// Copy engine shared by two requesters: copies selected elements of a source
// array M into a destination array N, one source element per clock.
// Ports:
//   Clk, Reset     clock and asynchronous active-low reset
//   Req            per-requester level request
//   Mode0, Mode1   copy mode of requester 0/1, latched at grant
//   Ack            per-requester completion acknowledge (only the owner's counts)
//   Ms_of_I        source data M[I], combinational from I
//   Grant          one-hot owner, 00 while idle
//   I, J           source read index / destination write index
//   Ns_of_J_Write  N[J] <= M[I] at this rising edge
//   Done           high in DONE
//   Count          elements written by the current job (equals J)
//   State          one-hot state code
// Handshake: a requester holds Req until it sees its Grant bit; the job then
// runs without further input and Done stays high until the owner pulses its
// Ack bit. Req seen outside INI is ignored; a Req still high after Ack is
// arbitrated again in INI.
module copy_array_scheduler
  import copy_sched_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    Req,
  input  logic [1:0]    Mode0,
  input  logic [1:0]    Mode1,
  input  logic [1:0]    Ack,
  input  logic [DW-1:0] Ms_of_I,
  output logic [1:0]    Grant,
  output logic [3:0]    I,
  output logic [3:0]    J,
  output logic          Ns_of_J_Write,
  output logic          Done,
  output logic [3:0]    Count,
  output logic [2:0]    State
);

  localparam logic [3:0] LAST_IDX = 4'(N_ELEM - 1);

  state_t     state_q, state_d;
  logic [1:0] grant_q;
  logic [1:0] mode_q;
  logic       pass_q;
  logic [3:0] i_q, j_q;

  logic [1:0] arb_grant;
  logic       ack_own;
  logic       last_idx;
  logic       end_job;
  logic       qual;
  logic       unused_data;

  // Only the sign bit decides whether an element is copied.
  assign unused_data = ^Ms_of_I;

  assign ack_own  = |(Ack & grant_q);
  assign last_idx = (i_q == LAST_IDX);
  // The final index ends the job unless it closes pass 0 of two-pass mode.
  assign end_job  = last_idx && !((mode_q == MODE_TWO) && !pass_q);
  assign qual     = qualifies(mode_q, pass_q, Ms_of_I[DW-1]);

  copy_rr_arb2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     (Req),
    .advance ((state_q == ST_DONE) && ack_own),
    .served  (grant_q[1]),
    .grant   (arb_grant)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_INI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INI:  if (|Req)   state_d = ST_COPY;
      ST_COPY: if (end_job) state_d = ST_DONE;
      ST_DONE: if (ack_own) state_d = ST_INI;
      default: state_d = ST_INI;
    endcase
  end

  // Output logic.
  always_comb begin
    Ns_of_J_Write = 1'b0;
    Done          = 1'b0;
    case (state_q)
      ST_COPY: Ns_of_J_Write = qual;
      ST_DONE: Done          = 1'b1;
      default: ;
    endcase
  end

  // Job datapath: owner, latched mode, pass flag and the two indices.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      grant_q <= 2'b00;
      mode_q  <= MODE_ALL;
      pass_q  <= 1'b0;
      i_q     <= 4'd0;
      j_q     <= 4'd0;
    end else begin
      case (state_q)
        ST_INI: begin
          if (|Req) begin
            grant_q <= arb_grant;
            mode_q  <= arb_grant[1] ? Mode1 : Mode0;
            pass_q  <= 1'b0;
            i_q     <= 4'd0;
            j_q     <= 4'd0;
          end
        end
        ST_COPY: begin
          if (Ns_of_J_Write) j_q <= j_q + 4'd1;
          if (!last_idx) begin
            i_q <= i_q + 4'd1;
          end else if (!end_job) begin
            // End of pass 0 in two-pass mode: rescan from the start.
            i_q    <= 4'd0;
            pass_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ack_own) grant_q <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // Grant reads 00 outside COPY/DONE even though grant_q is cleared on Ack.
  assign Grant = (state_q == ST_INI) ? 2'b00 : grant_q;
  assign I     = i_q;
  assign J     = j_q;
  assign Count = j_q;
  assign State = state_q;

endmodule

// File: tb/tb_copy_array_scheduler.sv
module tb_copy_array_scheduler;
  import copy_sched_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Req, Mode0, Mode1, Ack;
  logic [3:0] Ms_of_I;
  logic [1:0] Grant;
  logic [3:0] I, J, Count;
  logic       Ns_of_J_Write, Done;
  logic [2:0] State;

  always #5 Clk = ~Clk;

  logic [3:0] m_arr [10];
  assign Ms_of_I = (I < 4'd10) ? m_arr[I] : 4'd0;

  copy_array_scheduler #(.N_ELEM(10), .DW(4)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Mode0(Mode0), .Mode1(Mode1),
    .Ack(Ack), .Ms_of_I(Ms_of_I), .Grant(Grant), .I(I), .J(J),
    .Ns_of_J_Write(Ns_of_J_Write), .Done(Done), .Count(Count), .State(State)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];       // {state, J, data} per expected write
  logic [13:0] exp_done_q[$];  // {grant, count, latency} per expected job

  int   cyc = 0;
  int   grant_cyc = 0;
  logic prev_grant_nz = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a write or a job end.
  always @(negedge Clk) begin
    logic [10:0] ew;
    logic [13:0] ed;
    if (Ns_of_J_Write === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got J=%0h data=%0h want none", J, Ms_of_I);
      end else begin
        ew = exp_q.pop_front();
        if ({State, J, Ms_of_I} !== ew) begin
          bad++;
          $display("FAIL write: got st=%0h J=%0h d=%0h want st=%0h J=%0h d=%0h",
                   State, J, Ms_of_I, ew[10:8], ew[7:4], ew[3:0]);
        end
      end
    end
    if (Grant != 2'b00 && !prev_grant_nz) grant_cyc = cyc;
    if (Done === 1'b1 && !prev_done) begin
      total++;
      if (exp_done_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got grant=%0h count=%0h want none", Grant, Count);
      end else begin
        ed = exp_done_q.pop_front();
        if ({Grant, Count, 8'(cyc - grant_cyc)} !== ed) begin
          bad++;
          $display("FAIL done: got grant=%0h count=%0d lat=%0d want grant=%0h count=%0d lat=%0d",
                   Grant, Count, cyc - grant_cyc, ed[13:12], ed[11:8], ed[7:0]);
        end
      end
    end
    prev_grant_nz = (Grant != 2'b00);
    prev_done     = (Done === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic load_m(input logic [39:0] v);
    for (int k = 0; k < 10; k++) m_arr[k] = v[39-4*k -: 4];
  endtask

  // Expected writes, nibbles listed left to right in write order.
  task automatic push_writes(input logic [39:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({ST_COPY, 4'(k), v[39-4*k -: 4]});
  endtask

  task automatic push_done(input logic [1:0] g, input logic [3:0] cnt, input logic [7:0] lat);
    exp_done_q.push_back({g, cnt, lat});
  endtask

  task automatic wait_grant();
    int n = 0;
    @(negedge Clk);
    while (Grant == 2'b00 && n < 6) begin @(negedge Clk); n++; end
    if (Grant == 2'b00) check("grant_timeout", 16'(Grant), 16'h1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (Done !== 1'b1 && n < 40) begin @(negedge Clk); n++; end
    if (Done !== 1'b1) check("done_timeout", 16'(Done), 16'h1);
  endtask

  task automatic ack_pulse(input logic [1:0] a);
    @(posedge Clk); #1 Ack = a;
    @(posedge Clk); #1 Ack = 2'b00;
  endtask

  // Single job: request, then scramble the mode inputs and drop Req once granted.
  task automatic run_job(input logic [1:0] req, input logic [1:0] m0, input logic [1:0] m1);
    @(posedge Clk); #1;
    Req = req; Mode0 = m0; Mode1 = m1;
    wait_grant();
    Mode0 = ~m0; Mode1 = ~m1; Req = 2'b00;
    wait_done();
  endtask

  task automatic do_reset();
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; Req = 2'b00; Mode0 = 2'b00; Mode1 = 2'b00; Ack = 2'b00;
    load_m(40'h2579ABCDEF);
    #2 Reset = 1'b0;
    #1;
    check("rst_state", 16'(State), 16'(ST_INI));
    check("rst_grant", 16'(Grant), 16'h0);
    check("rst_i", 16'(I), 16'h0);
    check("rst_j", 16'(J), 16'h0);
    check("rst_count", 16'(Count), 16'h0);
    check("rst_done", 16'(Done), 16'h0);
    check("rst_write", 16'(Ns_of_J_Write), 16'h0);
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;

    // R0 mode 00 on M1
    push_writes(40'h2579ABCDEF, 10); push_done(2'b01, 4'd10, 8'd10);
    run_job(2'b01, MODE_ALL, MODE_ALL);
    ack_pulse(2'b01);
    @(negedge Clk);
    check("ini_after_ack", 16'(State), 16'(ST_INI));
    check("ini_grant", 16'(Grant), 16'h0);

    // R1 mode 01 on M1
    push_writes(40'h9ABCDEF000, 7); push_done(2'b10, 4'd7, 8'd10);
    run_job(2'b10, MODE_ALL, MODE_NEG);
    check("done_write_low", 16'(Ns_of_J_Write), 16'h0);
    ack_pulse(2'b10);

    // R1 mode 11 on M1
    push_writes(40'h9ABCDEF257, 10); push_done(2'b10, 4'd10, 8'd20);
    run_job(2'b10, MODE_ALL, MODE_TWO);
    ack_pulse(2'b10);

    // R0 mode 01 on M4: nothing qualifies
    load_m(40'h0001234567);
    push_done(2'b01, 4'd0, 8'd10);
    run_job(2'b01, MODE_NEG, MODE_ALL);
    check("m4_j_zero", 16'(J), 16'h0);
    ack_pulse(2'b01);

    // Both requesting from reset: R0, then R1, then R0 again
    do_reset();
    load_m(40'h2579ABCDEF);
    push_writes(40'h2579ABCDEF, 10); push_done(2'b01, 4'd10, 8'd10);
    push_writes(40'h2570000000, 3);  push_done(2'b10, 4'd3, 8'd10);
    push_writes(40'h2579ABCDEF, 10); push_done(2'b01, 4'd10, 8'd10);
    @(posedge Clk); #1;
    Req = 2'b11; Mode0 = MODE_ALL; Mode1 = MODE_POS;
    wait_grant();
    wait_done();
    ack_pulse(2'b10);
    @(negedge Clk);
    check("other_ack_state", 16'(State), 16'(ST_DONE));
    check("other_ack_grant", 16'(Grant), 16'h1);
    check("done_i_held", 16'(I), 16'h9);
    ack_pulse(2'b01);
    wait_grant();
    wait_done();
    ack_pulse(2'b10);
    wait_grant();
    Req = 2'b00;
    wait_done();
    ack_pulse(2'b01);

    // Reset in the middle of a copy
    push_writes(40'h2579A00000, 5);
    @(posedge Clk); #1;
    Req = 2'b01; Mode0 = MODE_ALL;
    begin
      int n = 0;
      @(negedge Clk);
      while (!(State == ST_COPY && I == 4'd4) && n < 20) begin @(negedge Clk); n++; end
      check("reach_i4", 16'(I), 16'h4);
    end
    Req = 2'b00;
    #1 Reset = 1'b0;
    #1;
    check("mid_rst_state", 16'(State), 16'(ST_INI));
    check("mid_rst_grant", 16'(Grant), 16'h0);
    check("mid_rst_write", 16'(Ns_of_J_Write), 16'h0);
    check("mid_rst_ij", 16'({I, J}), 16'h0);
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
    push_writes(40'h9ABCDEF000, 7); push_done(2'b01, 4'd7, 8'd10);
    run_job(2'b01, MODE_NEG, MODE_ALL);
    ack_pulse(2'b01);

    repeat (3) @(negedge Clk);
    check("writes_left", 16'(exp_q.size()), 16'h0);
    check("dones_left", 16'(exp_done_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
